// File: rtl/button_conditioner.sv
// Pushbutton front end: synchronizes and debounces the step and mode buttons,
// latches the clock mode and produces single-cycle press strobes.

module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_raw_i,
    output logic level_o,
    output logic press_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   level_q, level_d;
    logic                   synced_s;
    logic                   last_s;
    logic                   press_s;

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign last_s   = (count_q == CW'(DEBOUNCE_CYCLES - 1));

    // Synchronizer chain for the asynchronous raw button
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        end
    end

    // Debounce next-state; the counter only advances below its terminal value
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        press_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (synced_s) begin
                    state_d = PRESS_CHK;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_CHK: begin
                if (!synced_s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (last_s) begin
                    state_d = PRESSED;
                    count_d = '0;
                    press_s = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!synced_s) begin
                    state_d = REL_CHK;
                    count_d = '0;
                end else begin
                    state_d = PRESSED;
                end
            end
            REL_CHK: begin
                if (synced_s) begin
                    state_d = PRESSED;
                    count_d = '0;
                end else if (last_s) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == REL_CHK);
    end

    // Debounce state, counter and registered level
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            count_q <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_s;
endmodule

module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        MODE_RESET      = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic step_btn_raw,
    input  logic mode_btn_raw,
    output logic step_level,
    output logic step_pulse,
    output logic mode,
    output logic mode_pulse
);
    logic step_level_s, step_press_s;
    logic mode_level_s, mode_press_s;
    logic step_pulse_q, step_pulse_d;
    logic mode_pulse_q, mode_pulse_d;
    logic mode_q, mode_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_step_db (
        .clk_i     (sys_clk),
        .rst_n_i   (rst_n),
        .btn_raw_i (step_btn_raw),
        .level_o   (step_level_s),
        .press_o   (step_press_s)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_mode_db (
        .clk_i     (sys_clk),
        .rst_n_i   (rst_n),
        .btn_raw_i (mode_btn_raw),
        .level_o   (mode_level_s),
        .press_o   (mode_press_s)
    );

    // Mode toggles as a mode strobe ends; step gating sees the mode of the strobe cycle
    always_comb begin
        mode_d       = mode_q ^ mode_pulse_q;
        mode_pulse_d = mode_press_s;
        step_pulse_d = step_press_s & mode_d;
    end

    // Output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_RESET;
            mode_pulse_q <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            mode_pulse_q <= mode_pulse_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign step_level = step_level_s;
    assign step_pulse = step_pulse_q;
    assign mode       = mode_q;
    assign mode_pulse = mode_pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: per-cycle scoreboard against a
// run-length debounce model, a vector table and directed corner sequences.

module tb_button_conditioner;
    localparam int DB = 4;
    localparam int SS = 2;

    logic sys_clk = 1'b0;
    logic rst_n = 1'b0;
    logic step_btn_raw = 1'b0;
    logic mode_btn_raw = 1'b0;
    logic step_level, step_pulse, mode, mode_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .MODE_RESET      (1'b0)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .step_btn_raw (step_btn_raw),
        .mode_btn_raw (mode_btn_raw),
        .step_level   (step_level),
        .step_pulse   (step_pulse),
        .mode         (mode),
        .mode_pulse   (mode_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit level;
        bit spulse;
        bit mode;
        bit mpulse;
    } exp_t;

    typedef struct {
        bit step_raw;
        bit mode_raw;
        bit exp_level;
        bit exp_spulse;
        bit exp_mode;
        bit exp_mpulse;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_spulse = 0;
    int   n_mpulse = 0;

    bit [SS-1:0] m_sync_s, m_sync_m;
    bit m_lvl_s, m_lvl_m, m_mode, m_mpulse, m_spulse;
    int m_run_s, m_run_m;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync_s = '0; m_sync_m = '0;
        m_lvl_s = 1'b0; m_lvl_m = 1'b0;
        m_run_s = 0; m_run_m = 0;
        m_mode = 1'b0; m_mpulse = 1'b0; m_spulse = 1'b0;
        sb_q.delete();
    endtask

    // Level flips once DB+1 consecutive synced samples disagree with it
    task automatic db_model(input bit s, inout bit lvl, inout int run, output bit press);
        press = 1'b0;
        if (s != lvl) begin
            run++;
            if (run == DB + 1) begin
                lvl = s;
                run = 0;
                press = s;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge();
        bit ss, sm, ps, pm, nmode;
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else begin
            ss = m_sync_s[SS-1];
            sm = m_sync_m[SS-1];
            m_sync_s = {m_sync_s[SS-2:0], step_btn_raw};
            m_sync_m = {m_sync_m[SS-2:0], mode_btn_raw};
            db_model(ss, m_lvl_s, m_run_s, ps);
            db_model(sm, m_lvl_m, m_run_m, pm);
            nmode    = m_mode ^ m_mpulse;
            m_mpulse = pm;
            m_spulse = ps & nmode;
            m_mode   = nmode;
        end
        e.level = m_lvl_s; e.spulse = m_spulse; e.mode = m_mode; e.mpulse = m_mpulse;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge sys_clk);
        model_edge();
        #1;
        cyc++;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("sb_step_level", step_level, e.level);
            chk("sb_step_pulse", step_pulse, e.spulse);
            chk("sb_mode",       mode,       e.mode);
            chk("sb_mode_pulse", mode_pulse, e.mpulse);
        end
        if (step_pulse) n_spulse++;
        if (mode_pulse) n_mpulse++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_mode();
        mode_btn_raw = 1'b1;
        run(12);
        mode_btn_raw = 1'b0;
        run(12);
    endtask

    vec_t tbl[12];

    initial begin
        int base_s, base_m, rise;
        bit lvl_ok;

        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, (i + 1 >= 8), (i + 1 == 7)};
        end

        model_reset();
        run(3);
        chk("reset_step_level", step_level, 0);
        chk("reset_step_pulse", step_pulse, 0);
        chk("reset_mode",       mode,       0);
        chk("reset_mode_pulse", mode_pulse, 0);
        rst_n = 1'b1;

        // Clean mode press: strobe on edge 7, mode set on edge 8
        for (int i = 0; i < 12; i++) begin
            step_btn_raw = tbl[i].step_raw;
            mode_btn_raw = tbl[i].mode_raw;
            tick();
            chk("tbl_step_level", step_level, tbl[i].exp_level);
            chk("tbl_step_pulse", step_pulse, tbl[i].exp_spulse);
            chk("tbl_mode",       mode,       tbl[i].exp_mode);
            chk("tbl_mode_pulse", mode_pulse, tbl[i].exp_mpulse);
        end
        mode_btn_raw = 1'b0;
        run(12);
        chk("first_press_pulses", n_mpulse, 1);

        press_mode();
        chk("second_press_mode", mode, 0);
        chk("second_press_pulses", n_mpulse, 2);

        // Gating: mode=0, held step press gives level but no strobe
        base_s = n_spulse;
        step_btn_raw = 1'b1;
        run(6);
        chk("gate_level_e6", step_level, 0);
        tick();
        chk("gate_level_e7", step_level, 1);
        run(5);
        chk("gate_no_pulse", n_spulse - base_s, 0);
        step_btn_raw = 1'b0;
        run(12);
        chk("gate_release_level", step_level, 0);

        press_mode();
        chk("mode_set_for_bounce", mode, 1);

        // Bounce 1,0,1,0 then held; final rising sample edge is index 5
        base_s = n_spulse;
        rise = 0;
        for (int i = 1; i <= 20; i++) begin
            step_btn_raw = (i < 5) ? ((i % 2) == 1) : 1'b1;
            tick();
            if (step_level && rise == 0) rise = i;
        end
        chk("bounce_rise_edge", rise - 5 + 1, 7);
        chk("bounce_one_pulse", n_spulse - base_s, 1);

        // Release glitch of two cycles while held
        base_s = n_spulse;
        lvl_ok = 1'b1;
        step_btn_raw = 1'b0;
        for (int i = 0; i < 2; i++) begin tick(); if (!step_level) lvl_ok = 1'b0; end
        step_btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (!step_level) lvl_ok = 1'b0; end
        chk("glitch_level_held", lvl_ok, 1);
        chk("glitch_no_pulse", n_spulse - base_s, 0);
        step_btn_raw = 1'b0;
        run(12);

        // Simultaneous press with mode=1
        step_btn_raw = 1'b1;
        mode_btn_raw = 1'b1;
        run(7);
        chk("simul_step_pulse", step_pulse, 1);
        chk("simul_mode_pulse", mode_pulse, 1);
        chk("simul_mode_e7", mode, 1);
        tick();
        chk("simul_mode_e8", mode, 0);
        step_btn_raw = 1'b0;
        mode_btn_raw = 1'b0;
        run(12);

        press_mode();
        chk("mode_set_for_reset", mode, 1);

        // Reset mid-press at count=2, step held through deassertion
        base_s = n_spulse;
        base_m = n_mpulse;
        step_btn_raw = 1'b1;
        run(5);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_level", step_level, 0);
        chk("rst_mid_mode",  mode,       0);
        chk("rst_mid_spulse", step_pulse, 0);
        chk("rst_mid_mpulse", mode_pulse, 0);
        run(3);
        rst_n = 1'b1;
        run(6);
        chk("rst_rise_e6", step_level, 0);
        tick();
        chk("rst_rise_e7", step_level, 1);
        run(5);
        chk("rst_no_step_pulse", n_spulse - base_s, 0);
        chk("rst_no_mode_pulse", n_mpulse - base_m, 0);
        step_btn_raw = 1'b0;
        run(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
